// File: rtl/alu_result_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_result_checker
//  Purpose  : Response monitor for the 4-bit lab ALU. Registers each accepted
//             operand/opcode/result vector, recomputes the expected 5-bit
//             result one edge later, and keeps pass/fail counts. It signals
//             done after NUM_VEC comparisons.
//  Options  : ALU_CHK_FIRST_ERR_EN - when defined, builds the first-error
//             capture registers (index, expected, observed). When undefined,
//             those outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker #(
  parameter int NUM_VEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] sel,
  input  logic [4:0] aluo,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] pass_cnt,
  output logic [7:0] err_cnt,
  output logic [7:0] first_err_idx,
  output logic [4:0] first_err_exp,
  output logic [4:0] first_err_got
);

  localparam logic [7:0] VEC_LIMIT = 8'(NUM_VEC);
  localparam logic [7:0] LAST_IDX  = 8'(NUM_VEC - 1);
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;

  // Stage-1 pipeline: the vector exactly as it was applied to the ALU
  logic       s1_valid;
  logic [3:0] s1_a;
  logic [3:0] s1_b;
  logic [1:0] s1_sel;
  logic [4:0] s1_got;
  logic [7:0] s1_idx;

  // Number of vectors accepted in the current run (also the next index)
  logic [7:0] acc_cnt;

  logic       clear;
  logic       accept;
  logic [4:0] exp_val;
  logic       result_ok;
  logic       record;
  logic       last_cmp;

  // A start outside RUN opens a new run; it wins over any same-cycle vector
  // because accept is only true in RUN.
  assign clear    = start && (state != RUN);
  assign accept   = (state == RUN) && in_valid && (acc_cnt < VEC_LIMIT);

  // Stage 2 only records while the run is live; a stage-1 entry can only
  // exist in RUN, but the guard keeps the counters safe regardless.
  assign record   = s1_valid && (state == RUN);
  assign result_ok = (exp_val == s1_got);
  assign last_cmp = record && (s1_idx == LAST_IDX);

  // Stage 1: capture accepted vectors; the clearing edge flushes the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= 4'd0;
      s1_b     <= 4'd0;
      s1_sel   <= 2'd0;
      s1_got   <= 5'd0;
      s1_idx   <= 8'd0;
      acc_cnt  <= 8'd0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      acc_cnt  <= 8'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= A;
        s1_b    <= B;
        s1_sel  <= sel;
        s1_got  <= aluo;
        s1_idx  <= acc_cnt;
        acc_cnt <= acc_cnt + 8'd1;
      end
    end
  end

  // Reference ALU model, all arithmetic carried out 5 bits wide
  always_comb begin
    exp_val = 5'd0;
    case (s1_sel)
      2'b00:   exp_val = {1'b0, s1_a} + {1'b0, s1_b};
      2'b01:   exp_val = {1'b0, s1_a} - {1'b0, s1_b};
      2'b10:   exp_val = {1'b0, s1_a & s1_b};
      default: exp_val = {1'b0, s1_a | s1_b};
    endcase
  end

  // Run-control FSM; busy and done are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          // start is deliberately ignored here
          if (last_cmp) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: score the registered vector, saturating counters, mismatch pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= 8'd0;
      err_cnt  <= 8'd0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (clear) begin
        pass_cnt <= 8'd0;
        err_cnt  <= 8'd0;
      end else if (record) begin
        if (result_ok) begin
          if (pass_cnt != CNT_MAX) begin
            pass_cnt <= pass_cnt + 8'd1;
          end
        end else begin
          mismatch <= 1'b1;
          if (err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
      end
    end
  end

`ifdef ALU_CHK_FIRST_ERR_EN
  // First-error capture: loads only on the mismatch that finds err_cnt at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_idx <= 8'd0;
      first_err_exp <= 5'd0;
      first_err_got <= 5'd0;
    end else if (clear) begin
      first_err_idx <= 8'd0;
      first_err_exp <= 5'd0;
      first_err_got <= 5'd0;
    end else if (record && !result_ok && (err_cnt == 8'd0)) begin
      first_err_idx <= s1_idx;
      first_err_exp <= exp_val;
      first_err_got <= s1_got;
    end
  end
`else
  // Capture registers not built; report a constant zero
  assign first_err_idx = 8'd0;
  assign first_err_exp = 5'd0;
  assign first_err_got = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_checker
//  Purpose  : Scoreboard bench for alu_result_checker (NUM_VEC = 5). Each
//             accepted vector pushes its expected outcome; a negedge monitor
//             pops it when the DUT result is due and checks mismatch and the
//             counters against a bench-side model. Honours
//             ALU_CHK_FIRST_ERR_EN for the first-error outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;

  localparam int NV = 5;

`ifdef ALU_CHK_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic [1:0] sel = 2'd0;
  logic [4:0] aluo = 5'd0;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [7:0] pass_cnt;
  logic [7:0] err_cnt;
  logic [7:0] first_err_idx;
  logic [4:0] first_err_exp;
  logic [4:0] first_err_got;

  alu_result_checker #(.NUM_VEC(NV)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .A             (A),
    .B             (B),
    .sel           (sel),
    .aluo          (aluo),
    .busy          (busy),
    .done          (done),
    .mismatch      (mismatch),
    .pass_cnt      (pass_cnt),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: integer arithmetic folded into 0..31
  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
    int r;
    case (s)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = (int'(a) - int'(b) + 32) % 32;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return r[4:0];
  endfunction

  typedef struct {
    int         due;
    logic [4:0] exp;
    logic [4:0] got;
    logic [7:0] idx;
  } sb_t;

  sb_t sb[$];

  // Bench model of run state and expected counter values
  bit         m_run = 1'b0;
  int         m_acc = 0;
  int         m_pass = 0;
  int         m_err = 0;
  logic [7:0] m_fidx = 8'd0;
  logic [4:0] m_fexp = 5'd0;
  logic [4:0] m_fgot = 5'd0;
  bit         mon_en = 1'b1;

  // Monitor: compare DUT outputs when a scoreboard entry comes due
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        sb_t e;
        e = sb.pop_front();
        if (e.exp != e.got) begin
          if (m_err == 0) begin
            m_fidx = e.idx;
            m_fexp = e.exp;
            m_fgot = e.got;
          end
          m_err++;
        end else begin
          m_pass++;
        end
        check("mismatch", mismatch, (e.exp != e.got));
        check("pass_cnt", pass_cnt, m_pass);
        check("err_cnt", err_cnt, m_err);
        check("first_err_idx", first_err_idx, FE_EN ? m_fidx : 8'd0);
        check("first_err_exp", first_err_exp, FE_EN ? m_fexp : 5'd0);
        check("first_err_got", first_err_got, FE_EN ? m_fgot : 5'd0);
        if (m_pass + m_err == NV) begin
          check("done_on_last", done, 1);
          check("busy_on_last", busy, 0);
        end
      end else if (busy || done) begin
        check("mismatch_quiet", mismatch, 0);
      end
    end
  end

  // Apply one vector for one cycle; called at posedge+1
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                      input logic [4:0] g, input bit st);
    A = a; B = b; sel = s; aluo = g; in_valid = 1'b1; start = st;
    if (m_run && m_acc < NV) begin
      sb.push_back('{due: cyc + 2, exp: ref_alu(a, b, s), got: g, idx: 8'(m_acc)});
      m_acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0;
  endtask

  // Start a run, optionally with a bad stray vector on the same cycle
  task automatic start_run(input bit stray);
    start = 1'b1;
    if (stray) begin
      A = 4'd15; B = 4'd15; sel = 2'd0; aluo = 5'd0; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    m_run = 1'b1; m_acc = 0; m_pass = 0; m_err = 0;
    m_fidx = 8'd0; m_fexp = 5'd0; m_fgot = 5'd0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("pass_clear", pass_cnt, 0);
    check("err_clear", err_cnt, 0);
    check("fidx_clear", first_err_idx, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1);
    @(negedge clk); #1;
    check("queue_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_pass"}, pass_cnt, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_fidx"}, first_err_idx, 0);
    check({tag, "_fexp"}, first_err_exp, 0);
    check({tag, "_fgot"}, first_err_got, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Vectors in IDLE are ignored
    send(4'd1, 4'd1, 2'd0, 5'd0, 1'b0);
    send(4'd2, 4'd3, 2'd1, 5'd7, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("idle_pass", pass_cnt, 0);
    check("idle_err", err_cnt, 0);
    check("idle_busy", busy, 0);

    // Nominal run, back-to-back, plus a bad 6th vector that must be dropped
    start_run(1'b0);
    send(4'd7,  4'd8,  2'd0, 5'd15, 1'b0);
    send(4'd8,  4'd9,  2'd1, 5'd31, 1'b0);
    send(4'd9,  4'd10, 2'd2, 5'd8,  1'b0);
    send(4'd10, 4'd11, 2'd3, 5'd11, 1'b0);
    send(4'd3,  4'd12, 2'd0, 5'd15, 1'b0);
    send(4'd1,  4'd1,  2'd0, 5'd0,  1'b0);
    wait_done();
    check("nom_pass", pass_cnt, 5);
    check("nom_err", err_cnt, 0);

    // Stray vector in DONE is ignored
    send(4'd4, 4'd4, 2'd0, 5'd1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("done_hold", done, 1);
    check("done_pass", pass_cnt, 5);
    check("done_err", err_cnt, 0);

    // Restart with a stray vector on the start cycle; injected error at index 2
    start_run(1'b1);
    send(4'd1,  4'd2,  2'd0, 5'd3,  1'b0);
    send(4'd5,  4'd3,  2'd1, 5'd2,  1'b0);
    send(4'd15, 4'd1,  2'd0, 5'd0,  1'b0);
    send(4'd12, 4'd10, 2'd2, 5'd8,  1'b0);
    send(4'd0,  4'd15, 2'd3, 5'd15, 1'b0);
    wait_done();
    check("inj_pass", pass_cnt, 4);
    check("inj_err", err_cnt, 1);
    check("inj_fexp", first_err_exp, FE_EN ? 5'd16 : 5'd0);
    check("inj_fgot", first_err_got, 0);
    check("inj_fidx", first_err_idx, FE_EN ? 8'd2 : 8'd0);

    // Errors at indices 1 and 3; a start pulse mid-run must be ignored
    start_run(1'b0);
    send(4'd2, 4'd2, 2'd0, 5'd4, 1'b0);
    send(4'd3, 4'd5, 2'd1, 5'd0, 1'b0);
    send(4'd6, 4'd3, 2'd2, 5'd2, 1'b1);
    send(4'd4, 4'd1, 2'd3, 5'd0, 1'b0);
    send(4'd9, 4'd9, 2'd1, 5'd0, 1'b0);
    wait_done();
    check("multi_pass", pass_cnt, 3);
    check("multi_err", err_cnt, 2);
    check("multi_fidx", first_err_idx, FE_EN ? 8'd1 : 8'd0);
    check("multi_fexp", first_err_exp, FE_EN ? 5'd30 : 5'd0);

    // Asynchronous reset mid-run after two vectors
    start_run(1'b0);
    send(4'd1, 4'd1, 2'd0, 5'd2, 1'b0);
    send(4'd2, 4'd1, 2'd1, 5'd9, 1'b0);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1 check_all_zero("async_rst");
    sb.delete();
    m_run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    send(4'd3, 4'd3, 2'd0, 5'd6, 1'b0);
    send(4'd3, 4'd3, 2'd0, 5'd1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_all_zero("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
